basic_dff_enable: RTL and testbench



---
 rtl/basic_dff_enable.sv | 73 +++++++
 tb/tb_basic_dff_enable.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/basic_dff_enable.sv
// Rising-edge D flip-flop with load enable, synchronous active-high reset and
// complementary outputs; behavioural or gate-level master-slave form per bit.
module basic_dff_enable #(
   parameter int               WIDTH      = 1,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter bit               STRUCTURAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n
);

   if (STRUCTURAL == 1'b0) begin : g_beh

      logic [WIDTH-1:0] q_r;

      always_ff @(posedge clk) begin
         if (rst) begin
            q_r <= RESET_VAL;
         end else if (en) begin
            q_r <= d;
         end
      end

      assign q   = q_r;
      assign q_n = ~q_r;

   end else begin : g_gate

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit

         logic sel_d_n;
         logic rst_d_n;
         logic m;
         logic s;
         logic s_n;

         // Input steering in NAND form. The hold leg is the master's own
         // output: during the transparent low phase it equals q, because the
         // slave copied it at the previous rising edge.
         assign sel_d_n = ~(en & d[i]);
         assign rst_d_n = ~rst;

         // Master latch: transparent while clk is low.
         always_latch begin
            if (!clk) begin
               if (!rst_d_n) begin
                  m <= RESET_VAL[i];
               end else if (en) begin
                  m <= ~sel_d_n;
               end
            end
         end

         // Slave latch: transparent while clk is high, drives both rails.
         always_latch begin
            if (clk) begin
               s   <= m;
               s_n <= ~m;
            end
         end

         assign q[i]   = s;
         assign q_n[i] = s_n;

      end

   end

endmodule

// File: tb/tb_basic_dff_enable.sv
// Directed and lockstep-random checks of basic_dff_enable in several
// parameterisations; clock is 5 ns high / 2 ns low, rising edges at 7, 14, ...
`timescale 1ns/100ps
module tb_basic_dff_enable;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] d;

   logic       qa, qna;    // WIDTH=1, RESET_VAL=0, behavioural
   logic       qb, qnb;    // WIDTH=1, RESET_VAL=1, behavioural
   logic       qg, qng;    // WIDTH=1, RESET_VAL=1, structural
   logic [7:0] qc, qnc;    // WIDTH=8, RESET_VAL=3C, behavioural
   logic [7:0] qs, qns;    // WIDTH=8, RESET_VAL=3C, structural

   int checks = 0;
   int errors = 0;
   int ev_a = 0;
   int ev_c = 0;
   int ev_s = 0;

   logic [7:0] exp_q[$];

   basic_dff_enable #(.WIDTH(1), .RESET_VAL(1'b0), .STRUCTURAL(1'b0)) u_a (
      .clk(clk), .rst(rst), .en(en), .d(d[0]), .q(qa), .q_n(qna));
   basic_dff_enable #(.WIDTH(1), .RESET_VAL(1'b1), .STRUCTURAL(1'b0)) u_b (
      .clk(clk), .rst(rst), .en(en), .d(d[0]), .q(qb), .q_n(qnb));
   basic_dff_enable #(.WIDTH(1), .RESET_VAL(1'b1), .STRUCTURAL(1'b1)) u_g (
      .clk(clk), .rst(rst), .en(en), .d(d[0]), .q(qg), .q_n(qng));
   basic_dff_enable #(.WIDTH(8), .RESET_VAL(8'h3C), .STRUCTURAL(1'b0)) u_c (
      .clk(clk), .rst(rst), .en(en), .d(d), .q(qc), .q_n(qnc));
   basic_dff_enable #(.WIDTH(8), .RESET_VAL(8'h3C), .STRUCTURAL(1'b1)) u_s (
      .clk(clk), .rst(rst), .en(en), .d(d), .q(qs), .q_n(qns));

   // clock and reset
   initial begin
      clk = 1'b0;
      #7 clk = 1'b1;
      forever begin
         #5 clk = 1'b0;
         #2 clk = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   always @(qa) ev_a++;
   always @(qc) ev_c++;
   always @(qs) ev_s++;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic r, input logic e, input logic [7:0] dv);
      @(negedge clk);
      rst = r;
      en  = e;
      d   = dv;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_w8(input string tag, input logic [7:0] exp);
      check({tag, "_q"},    qc,  exp);
      check({tag, "_qn"},   qnc, ~exp);
      check({tag, "_qs"},   qs,  exp);
      check({tag, "_qns"},  qns, ~exp);
   endtask

   initial begin
      int         e0_a, e0_c, e0_s;
      logic [7:0] model;
      logic [7:0] exp_v;
      logic       r, e;
      logic [7:0] dv;

      rst = 1'b1;
      en  = 1'b1;
      d   = 8'hFF;

      // reset overrides en with d all ones
      after_edge();
      check("rst_a_q",  qa,  8'h00);
      check("rst_a_qn", qna, 8'h01);
      check("rst_b_q",  qb,  8'h01);
      check("rst_g_q",  qg,  8'h01);
      check_w8("rst", 8'h3C);

      // reset with d=0, en=0 on RESET_VAL=1
      drive(1'b1, 1'b0, 8'h00);
      after_edge();
      check("rst1_b_q",  qb,  8'h01);
      check("rst1_b_qn", qnb, 8'h00);
      check("rst1_g_qn", qng, 8'h00);

      // load 1 then 0
      drive(1'b0, 1'b1, 8'hFF);
      after_edge();
      check("load1_a_q",  qa,  8'h01);
      check("load1_a_qn", qna, 8'h00);
      check("load1_b_q",  qb,  8'h01);
      check_w8("load1", 8'hFF);
      drive(1'b0, 1'b1, 8'h00);
      after_edge();
      check("load0_a_q",  qa,  8'h00);
      check("load0_a_qn", qna, 8'h01);
      check("load0_g_q",  qg,  8'h00);
      check_w8("load0", 8'h00);
      drive(1'b0, 1'b1, 8'h81);
      after_edge();
      check_w8("load81", 8'h81);
      check("load81_a_q", qa, 8'h01);

      // hold for three edges while d toggles every 1 ns
      drive(1'b0, 1'b0, 8'h81);
      e0_a = ev_a;
      e0_c = ev_c;
      e0_s = ev_s;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(posedge clk);
         for (int k = 0; k < 6; k++) begin
            #1 d = ~d;
         end
      end
      check("hold_a_q", qa, 8'h01);
      check_w8("hold", 8'h81);
      check("hold_ev_a", 8'(ev_a - e0_a), 8'h00);
      check("hold_ev_c", 8'(ev_c - e0_c), 8'h00);
      check("hold_ev_s", 8'(ev_s - e0_s), 8'h00);

      // glitches within the high phase, settling to ones before the edge
      drive(1'b0, 1'b1, 8'h00);
      after_edge();
      check_w8("glitch_pre", 8'h00);
      e0_c = ev_c;
      e0_s = ev_s;
      #0.5 d = 8'hFF;
      #1   d = 8'h00;
      #1   d = 8'hFF;
      #1   d = 8'h00;
      @(negedge clk);
      d = 8'hFF;
      #1;
      check_w8("glitch_noprop", 8'h00);
      check("glitch_ev_before", 8'(ev_s - e0_s), 8'h00);
      after_edge();
      check_w8("glitch_edge", 8'hFF);
      check("glitch_a_q", qa, 8'h01);
      check("glitch_ev_c", 8'(ev_c - e0_c), 8'h01);
      check("glitch_ev_s", 8'(ev_s - e0_s), 8'h01);

      // reset priority over a pending load of A5
      drive(1'b1, 1'b1, 8'hA5);
      after_edge();
      check_w8("rstpri", 8'h3C);
      check("rstpri_a_q", qa, 8'h00);
      drive(1'b0, 1'b1, 8'hA5);
      after_edge();
      check_w8("rstrel", 8'hA5);
      check("rstrel_a_q", qa, 8'h01);

      // enable window: loads on each enabled edge, then freezes
      drive(1'b0, 1'b1, 8'h11);
      after_edge();
      check_w8("win1", 8'h11);
      drive(1'b0, 1'b1, 8'h22);
      after_edge();
      check_w8("win2", 8'h22);
      drive(1'b0, 1'b1, 8'h33);
      after_edge();
      check_w8("win3", 8'h33);
      drive(1'b0, 1'b0, 8'h44);
      after_edge();
      check_w8("frz1", 8'h33);
      drive(1'b0, 1'b0, 8'h55);
      after_edge();
      check_w8("frz2", 8'h33);

      // random lockstep phase against a reference model
      model = 8'h33;
      for (int n = 0; n < 1000; n++) begin
         r  = ($urandom_range(0, 9) == 0);
         e  = 1'($urandom_range(0, 1));
         dv = 8'($urandom_range(0, 255));
         drive(r, e, dv);
         if (r)      model = 8'h3C;
         else if (e) model = dv;
         exp_q.push_back(model);
         after_edge();
         exp_v = exp_q.pop_front();
         check("rnd_q",   qc,  exp_v);
         check("rnd_qs",  qs,  exp_v);
         check("rnd_qns", qns, ~exp_v);
         check("rnd_eqv", qs,  qc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
